// File: rtl/sorted_pkt_tx.sv
// Sort-path transmitter: streams L words from a synchronous-read buffer as an Avalon-ST packet.
// Define SORT_TX_DESCENDING_EN to read addresses L-1 down to 0 instead of 0 up to L-1.
module sorted_pkt_tx #(
  parameter int DWIDTH      = 10,
  parameter int MAX_PKT_LEN = 10,
  parameter int CTR_SZ      = 10,
  parameter int AWIDTH      = $clog2(MAX_PKT_LEN)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              start_i,
  input  logic [CTR_SZ-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o
);

`ifdef SORT_TX_DESCENDING_EN
  localparam bit DESCENDING = 1'b1;
`else
  localparam bit DESCENDING = 1'b0;
`endif

  localparam logic [CTR_SZ-1:0] ONE     = CTR_SZ'(1);
  localparam logic [CTR_SZ-1:0] MAX_LEN = CTR_SZ'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CTR_SZ-1:0] len_q;
  logic [CTR_SZ-1:0] rd_cnt;
  logic [CTR_SZ-1:0] beat_cnt;
  logic              ret_vld;

  logic [DWIDTH-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;

  logic              fifo_empty;
  logic              beat;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [1:0]        cnt_next;
  logic              last_beat;
  logic              can_read;
  logic [CTR_SZ-1:0] eff_len;

  function automatic logic [AWIDTH-1:0] addr_of(input logic [CTR_SZ-1:0] idx,
                                                input logic [CTR_SZ-1:0] len);
    return DESCENDING ? AWIDTH'(len - idx - ONE) : AWIDTH'(idx);
  endfunction

  // Data returning from the buffer bypasses an empty FIFO so the first beat
  // is visible the same cycle it arrives; otherwise the FIFO head is shown.
  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign src_valid_o = !fifo_empty || ret_vld;
  assign src_data_o  = !fifo_empty ? fifo_mem[rd_ptr] : (ret_vld ? rd_data_i : '0);
  assign beat        = src_valid_o && src_ready_i;
  assign fifo_wr     = ret_vld && !(fifo_empty && beat);
  assign fifo_rd     = beat && !fifo_empty;
  assign cnt_next    = fifo_cnt + 2'(ret_vld) - 2'(beat);

  assign last_beat           = (beat_cnt == len_q - ONE);
  assign src_startofpacket_o = src_valid_o && (beat_cnt == '0);
  assign src_endofpacket_o   = src_valid_o && last_beat;

  // Next-cycle occupancy plus the read now in flight must leave room for one more.
  assign can_read = (state == RUN) && (rd_cnt < len_q) &&
                    ((3'(cnt_next) + 3'(rd_en_o)) < 3'd2);
  assign eff_len  = (len_i > MAX_LEN) ? MAX_LEN : len_i;

  // NOTE: storage is deliberately left unreset; fifo_cnt/ret_vld gate every read of it.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= rd_data_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      ret_vld  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      ret_vld  <= rd_en_o;
      fifo_cnt <= cnt_next;
      if (fifo_wr) wr_ptr <= ~wr_ptr;
      if (fifo_rd) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      len_q     <= '0;
      rd_cnt    <= '0;
      beat_cnt  <= '0;
    end else begin
      done_o  <= 1'b0;
      rd_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state     <= RUN;
              busy_o    <= 1'b1;
              len_q     <= eff_len;
              beat_cnt  <= '0;
              rd_cnt    <= ONE;
              rd_en_o   <= 1'b1;
              rd_addr_o <= addr_of('0, eff_len);
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) beat_cnt <= beat_cnt + ONE;
          if (can_read) begin
            rd_en_o   <= 1'b1;
            rd_addr_o <= addr_of(rd_cnt, len_q);
            rd_cnt    <= rd_cnt + ONE;
          end
          if (beat && last_beat) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_pkt_tx.sv
// Directed bench for sorted_pkt_tx: framing, timing, backpressure, length edge cases, abort.
// Expected order follows SORT_TX_DESCENDING_EN when the bench is built with it.
module tb_sorted_pkt_tx;

`ifdef SORT_TX_DESCENDING_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic       clk;
  logic       arstn_i;
  logic       start_i;
  logic [9:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_en_o;
  logic [3:0] rd_addr_o;
  logic [9:0] rd_data_i = '0;
  logic [9:0] src_data_o;
  logic       src_valid_o;
  logic       src_ready_i;
  logic       src_startofpacket_o;
  logic       src_endofpacket_o;

  int checks   = 0;
  int failures = 0;

  sorted_pkt_tx dut (
    .clk_i               (clk),
    .arstn_i             (arstn_i),
    .start_i             (start_i),
    .len_i               (len_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .rd_en_o             (rd_en_o),
    .rd_addr_o           (rd_addr_o),
    .rd_data_i           (rd_data_i),
    .src_data_o          (src_data_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: word at address a holds value a, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= 10'(rd_addr_o);
  end

  // Starts one packet and follows it cycle by cycle until done_o.
  // pat gives ready per cycle from t0+2 onward (ready=1 past pat_len).
  task automatic run_pkt(input string name, input int len, input int exp_len,
                         input logic [15:0] pat, input int pat_len, input bit poke);
    int cyc, beats, reads, max_out, done_cyc, exp_addr;
    bit prev_stall, done_seen;
    logic [9:0] pdata, exp_d;
    logic psop, peop;
    @(negedge clk);
    start_i = 1'b1; len_i = 10'(len); src_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1; beats = 0; reads = 0; max_out = 0; done_cyc = -1;
    prev_stall = 1'b0; done_seen = 1'b0; pdata = '0; psop = 1'b0; peop = 1'b0;
    while (!done_seen && cyc < 80) begin
      src_ready_i = (cyc >= 2 && cyc - 2 < pat_len) ? pat[cyc-2] : 1'b1;
      if (poke) begin
        start_i = (cyc == 3);
        len_i   = 10'd2;
      end
      checks++;
      if (busy_o !== (beats < exp_len)) begin
        failures++;
        $display("FAIL %s busy cyc%0d: got=%b want=%b", name, cyc, busy_o, beats < exp_len);
      end
      checks++;
      if (done_o !== (beats == exp_len)) begin
        failures++;
        $display("FAIL %s done cyc%0d: got=%b want=%b", name, cyc, done_o, beats == exp_len);
      end
      if (cyc == 1) begin
        checks++;
        if (rd_en_o !== 1'b1) begin
          failures++;
          $display("FAIL %s first_read: rd_en=%b want=1", name, rd_en_o);
        end
      end
      if (rd_en_o) begin
        exp_addr = DESC ? exp_len - 1 - reads : reads;
        checks++;
        if (reads >= exp_len || rd_addr_o !== 4'(exp_addr)) begin
          failures++;
          $display("FAIL %s rd_addr read%0d: got=%0d want=%0d (limit %0d)",
                   name, reads, rd_addr_o, exp_addr, exp_len);
        end
        reads++;
      end
      if (reads - beats > max_out) max_out = reads - beats;
      if (pat_len == 0) begin
        checks++;
        if (src_valid_o !== (cyc >= 2 && cyc < 2 + exp_len)) begin
          failures++;
          $display("FAIL %s valid_timing cyc%0d: got=%b want=%b",
                   name, cyc, src_valid_o, cyc >= 2 && cyc < 2 + exp_len);
        end
      end
      if (prev_stall) begin
        checks++;
        if (src_valid_o !== 1'b1 || src_data_o !== pdata ||
            src_startofpacket_o !== psop || src_endofpacket_o !== peop) begin
          failures++;
          $display("FAIL %s stall_hold cyc%0d: got v=%b d=%0d sop=%b eop=%b want v=1 d=%0d sop=%b eop=%b",
                   name, cyc, src_valid_o, src_data_o, src_startofpacket_o,
                   src_endofpacket_o, pdata, psop, peop);
        end
      end
      if (src_valid_o) begin
        exp_d = DESC ? 10'(exp_len - 1 - beats) : 10'(beats);
        checks++;
        if (beats >= exp_len || src_data_o !== exp_d ||
            src_startofpacket_o !== (beats == 0) ||
            src_endofpacket_o !== (beats == exp_len - 1)) begin
          failures++;
          $display("FAIL %s beat%0d: got d=%0d sop=%b eop=%b want d=%0d sop=%b eop=%b",
                   name, beats, src_data_o, src_startofpacket_o, src_endofpacket_o,
                   exp_d, beats == 0, beats == exp_len - 1);
        end
      end
      prev_stall = src_valid_o && !src_ready_i;
      pdata = src_data_o; psop = src_startofpacket_o; peop = src_endofpacket_o;
      if (src_valid_o && src_ready_i) beats++;
      if (done_o) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL %s timeout: no done_o within %0d cycles", name, cyc);
    end
    checks++;
    if (beats != exp_len) begin
      failures++;
      $display("FAIL %s beat_count: got=%0d want=%0d", name, beats, exp_len);
    end
    checks++;
    if (max_out > 2) begin
      failures++;
      $display("FAIL %s outstanding: got=%0d want<=2", name, max_out);
    end
    if (pat_len == 0) begin
      checks++;
      if (done_cyc != exp_len + 2) begin
        failures++;
        $display("FAIL %s done_cycle: got=t0+%0d want=t0+%0d", name, done_cyc, exp_len + 2);
      end
    end
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || rd_en_o !== 1'b0 || src_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b rd_en=%b valid=%b want all 0",
               name, done_o, busy_o, rd_en_o, src_valid_o);
    end
  endtask

  task automatic test_reset();
    arstn_i = 1'b0; start_i = 1'b0; len_i = '0; src_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, rd_en_o, rd_addr_o, src_data_o, src_valid_o,
         src_startofpacket_o, src_endofpacket_o} !== '0) begin
      failures++;
      $display("FAIL reset_values: busy=%b done=%b rd_en=%b addr=%0d data=%0d v=%b sop=%b eop=%b want all 0",
               busy_o, done_o, rd_en_o, rd_addr_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o);
    end
    arstn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    run_pkt("full", 10, 10, 16'h0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    // ready 1,0,0,1,1,0,1 from t0+2, with a stray start while busy
    run_pkt("stall", 4, 4, 16'b0000_0000_0101_1001, 7, 1'b1);
  endtask

  task automatic test_single();
    run_pkt("single", 1, 1, 16'h0, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start_i = 1'b1; len_i = 10'd0; src_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || rd_en_o !== 1'b0 || src_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_len t0+1: done=%b busy=%b rd_en=%b valid=%b want 1 0 0 0",
               done_o, busy_o, rd_en_o, src_valid_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || rd_en_o !== 1'b0 || src_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_len t0+2: done=%b rd_en=%b valid=%b want 0 0 0",
               done_o, rd_en_o, src_valid_o);
    end
  endtask

  task automatic test_clamp();
    run_pkt("clamp", 15, 10, 16'h0, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    bit eop_seen;
    eop_seen = 1'b0;
    @(negedge clk);
    start_i = 1'b1; len_i = 10'd6; src_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    // beats 0..2 transfer at the ends of cycles t0+2..t0+4
    for (int c = 1; c < 5; c++) begin
      if (src_endofpacket_o) eop_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (src_valid_o !== 1'b1 || src_data_o !== (DESC ? 10'd2 : 10'd3)) begin
      failures++;
      $display("FAIL abort_live: valid=%b data=%0d want valid=1 data=%0d",
               src_valid_o, src_data_o, DESC ? 2 : 3);
    end
    arstn_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, rd_en_o, rd_addr_o, src_data_o, src_valid_o,
         src_startofpacket_o, src_endofpacket_o} !== '0 || eop_seen) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b rd_en=%b addr=%0d data=%0d v=%b sop=%b eop=%b early_eop=%b want all 0",
               busy_o, done_o, rd_en_o, rd_addr_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o, eop_seen);
    end
    #2;
    arstn_i = 1'b1;
    @(negedge clk);
    checks++;
    if (src_valid_o !== 1'b0 || busy_o !== 1'b0 || rd_en_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: valid=%b busy=%b rd_en=%b want 0 0 0",
               src_valid_o, busy_o, rd_en_o);
    end
    run_pkt("after_abort", 6, 6, 16'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_pkt("b2b_a", 3, 3, 16'h0, 0, 1'b0);
    run_pkt("b2b_b", 5, 5, 16'b0000_0000_0000_1010, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_backpressure();
    test_single();
    test_zero_len();
    test_clamp();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
